// File: rtl/eq_pkg.sv
// Shared types and constants for the 3-band EQ datapath.
// Coefficients and samples are signed Q2.14; the MAC accumulates in Q4.28.
package eq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_ISSUE     = 3'd2,
    S_DRAIN     = 3'd3,
    S_WRITEBACK = 3'd4,
    S_DONE      = 3'd5
  } sched_state_t;

  localparam int NTAPS   = 5;
  localparam int TAP_B0  = 0;
  localparam int TAP_B1  = 1;
  localparam int TAP_B2  = 2;
  localparam int TAP_NA1 = 3;
  localparam int TAP_NA2 = 4;

  localparam int Q_FRAC = 14;
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/q28_to_q14_sat.sv
// Narrows a signed Q4.28 accumulator to signed Q2.14, truncating toward -inf
// and clamping when the integer bits above the Q2.14 range disagree.
module q28_to_q14_sat
  import eq_pkg::*;
(
  input  logic [31:0] din,
  output logic [15:0] dout
);

  logic unused_frac;
  assign unused_frac = ^din[Q_FRAC-1:0];

  always_comb begin
    if (din[31:29] == 3'b000 || din[31:29] == 3'b111) begin
      dout = din[Q_FRAC+15:Q_FRAC];
    end else if (din[31]) begin
      dout = SAT_NEG;
    end else begin
      dout = SAT_POS;
    end
  end

endmodule

// File: rtl/biquad_mac_sched.sv
// Shares one external MAC across NBANDS biquad bands: per band it clears the
// accumulator, issues five taps, waits out the MAC latency and writes back.
module biquad_mac_sched
  import eq_pkg::*;
#(
  parameter int NBANDS  = 3,
  parameter int MAC_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [15:0]          x_in,
  input  logic                 coef_we,
  input  logic [3:0]           coef_addr,
  input  logic [15:0]          coef_wdata,
  output logic                 mac_rst,
  output logic                 ce,
  output logic [15:0]          a_in,
  output logic [15:0]          b_in,
  input  logic [31:0]          result,
  output logic [NBANDS*16-1:0] y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic [2:0]           fsm_state
);

  localparam int BW    = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int NCOEF = NBANDS * NTAPS;

  sched_state_t   state, next_state;
  logic [BW-1:0]  band;
  logic [3:0]     cnt;
  logic [15:0]    x0, x1, x2;
  logic [15:0]    y1 [NBANDS];
  logic [15:0]    y2 [NBANDS];
  logic [15:0]    coef [NCOEF];
  logic [15:0]    y_sat;
  logic [3:0]     coef_idx;
  logic           last_tap, last_drain, last_band;

  assign coef_idx   = 4'(int'(band) * NTAPS + int'(cnt));
  assign last_tap   = (cnt == 4'(NTAPS - 1));
  assign last_drain = (cnt == 4'(MAC_LAT - 1));
  assign last_band  = (band == BW'(NBANDS - 1));
  assign fsm_state  = state;

  q28_to_q14_sat u_sat (
    .din  (result),
    .dout (y_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (sample_valid) next_state = S_CLEAR;
      S_CLEAR:     next_state = S_ISSUE;
      S_ISSUE:     if (last_tap) next_state = S_DRAIN;
      S_DRAIN:     if (last_drain) next_state = S_WRITEBACK;
      S_WRITEBACK: next_state = last_band ? S_DONE : S_CLEAR;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // MAC interface: mac_rst is held low while reset is asserted as well as in CLEAR.
  always_comb begin
    mac_rst = reset && (state != S_CLEAR);
    ce      = 1'b0;
    a_in    = '0;
    b_in    = '0;
    if (state == S_ISSUE) begin
      ce   = 1'b1;
      a_in = coef[coef_idx];
      case (int'(cnt))
        TAP_B0:  b_in = x0;
        TAP_B1:  b_in = x1;
        TAP_B2:  b_in = x2;
        TAP_NA1: b_in = y1[band];
        default: b_in = y2[band];
      endcase
    end
    y_valid = (state == S_DONE);
    busy    = (state != S_IDLE);
    overrun = sample_valid && (state != S_IDLE);
  end

  // cnt counts taps in ISSUE and latency cycles in DRAIN; it restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      band  <= '0;
      x0    <= '0;
      x1    <= '0;
      x2    <= '0;
      y_out <= '0;
      for (int i = 0; i < NBANDS; i++) begin
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      cnt <= (next_state != state) ? 4'd0 : cnt + 4'd1;
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            x0   <= x_in;
            band <= '0;
          end
        end
        S_WRITEBACK: begin
          y_out[int'(band)*16 +: 16] <= y_sat;
          y2[band] <= y1[band];
          y1[band] <= y_sat;
          if (!last_band) band <= band + 1'b1;
        end
        S_DONE: begin
          x2 <= x1;
          x1 <= x0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
    end else if (coef_we && int'(coef_addr) < NCOEF) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

endmodule

// File: tb/tb_biquad_mac_sched.sv
// Bench for biquad_mac_sched with a behavioural 3-cycle-latency MAC attached.
// Directed vectors with hand-computed outputs, plus overrun and mid-run reset sequences.
module tb_biquad_mac_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] x_in;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        mac_rst, ce;
  logic [15:0] a_in, b_in;
  logic [31:0] result;
  logic [47:0] y_out;
  logic        y_valid, busy, overrun;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_cnt   = 0;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  biquad_mac_sched #(.NBANDS(3), .MAC_LAT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .mac_rst      (mac_rst),
    .ce           (ce),
    .a_in         (a_in),
    .b_in         (b_in),
    .result       (result),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy),
    .overrun      (overrun),
    .fsm_state    (fsm_state)
  );

  // MAC model: product register, accumulator, output register (3 cycles from last ce).
  logic signed [31:0] mac_p, mac_acc, mac_res;
  logic               mac_pv;
  assign result = mac_res;

  always @(posedge clk) begin
    if (mac_rst !== 1'b1) begin
      mac_p <= '0; mac_pv <= 1'b0; mac_acc <= '0; mac_res <= '0;
    end else begin
      mac_p   <= $signed(a_in) * $signed(b_in);
      mac_pv  <= ce;
      if (mac_pv) mac_acc <= mac_acc + mac_p;
      mac_res <= mac_acc;
    end
  end

  always @(posedge clk) if (ce === 1'b1) ce_cnt <= ce_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = addr; coef_wdata = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_cfg(input int cfg);
    do_reset();
    case (cfg)
      0: write_coef(4'd0, 16'h4000);
      1: begin
        write_coef(4'd5, 16'h0147); write_coef(4'd6, 16'h028E); write_coef(4'd7, 16'h0147);
      end
      2: begin write_coef(4'd10, 16'h4000); write_coef(4'd13, 16'h2000); end
      3: write_coef(4'd0, 16'h7FFF);
      4: write_coef(4'd0, 16'h2000);
      5: begin
        write_coef(4'd0, 16'h4000); write_coef(4'd5, 16'hC000);
        write_coef(4'd10, 16'h2000); write_coef(4'd15, 16'h4000);
      end
      6: begin write_coef(4'd0, 16'h4000); write_coef(4'd1, 16'h4000); end
      default: ;
    endcase
  endtask

  // Strobes one sample, optionally injects a second strobe at cycle ovr_at, checks result and timing.
  task automatic run_sample(input logic [15:0] x, input logic [47:0] exp, input int ovr_at);
    int got;
    logic [47:0] e;
    exp_q.push_back(exp);
    ce_cnt = 0;
    @(negedge clk);
    sample_valid = 1'b1; x_in = x;
    @(negedge clk);
    sample_valid = 1'b0;
    check("busy_start", 64'(busy), 64'd1);
    got = 0;
    for (int i = 1; i <= 40; i++) begin
      if (ovr_at > 0 && i == ovr_at) begin
        sample_valid = 1'b1; x_in = 16'h7000;
        #1;
        check("overrun_pulse", 64'(overrun), 64'd1);
      end else begin
        sample_valid = 1'b0;
      end
      if (y_valid === 1'b1) begin
        got = i;
        break;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("y_valid_cycle", 64'(got), 64'd31);
    e = exp_q.pop_front();
    check("y_out", 64'(y_out), 64'(e));
    check("ce_count", 64'(ce_cnt), 64'd15);
    check("busy_at_done", 64'(busy), 64'(got != 0));
    @(negedge clk);
    check("busy_end", 64'(busy), 64'd0);
  endtask

  typedef struct {
    int          cfg;
    logic [15:0] x;
    logic [47:0] exp_y;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic saw_yv;
    vecs[0]  = '{0,  16'h2000, 48'h0000_0000_2000};
    vecs[1]  = '{1,  16'h4000, 48'h0000_0147_0000};
    vecs[2]  = '{-1, 16'h0000, 48'h0000_028E_0000};
    vecs[3]  = '{-1, 16'h0000, 48'h0000_0147_0000};
    vecs[4]  = '{-1, 16'h0000, 48'h0000_0000_0000};
    vecs[5]  = '{2,  16'h4000, 48'h4000_0000_0000};
    vecs[6]  = '{-1, 16'h0000, 48'h2000_0000_0000};
    vecs[7]  = '{-1, 16'h0000, 48'h1000_0000_0000};
    vecs[8]  = '{-1, 16'h0000, 48'h0800_0000_0000};
    vecs[9]  = '{3,  16'h7FFF, 48'h0000_0000_7FFF};
    vecs[10] = '{-1, 16'h8000, 48'h0000_0000_8000};
    vecs[11] = '{4,  16'hFFFF, 48'h0000_0000_FFFF};
    vecs[12] = '{-1, 16'h0001, 48'h0000_0000_0000};
    vecs[13] = '{5,  16'h1000, 48'h0800_F000_1000};

    reset = 1'b0; sample_valid = 1'b0; x_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    #1;
    check("rst_mac_rst", 64'(mac_rst), 64'd0);
    check("rst_ce", 64'(ce), 64'd0);
    check("rst_a_in", 64'(a_in), 64'd0);
    check("rst_b_in", 64'(b_in), 64'd0);
    check("rst_y_out", 64'(y_out), 64'd0);
    check("rst_flags", 64'({y_valid, busy, overrun}), 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_mac_rst", 64'(mac_rst), 64'd1);

    for (int v = 0; v < 14; v++) begin
      if (vecs[v].cfg >= 0) load_cfg(vecs[v].cfg);
      run_sample(vecs[v].x, vecs[v].exp_y, 0);
    end

    // Dropped sample must not disturb x history.
    load_cfg(6);
    run_sample(16'h2000, 48'h0000_0000_2000, 10);
    run_sample(16'h0000, 48'h0000_0000_2000, 0);

    // Reset at k+15 with feedback history present, then a zero sample sees zero history.
    load_cfg(2);
    run_sample(16'h4000, 48'h4000_0000_0000, 0);
    @(negedge clk);
    sample_valid = 1'b1; x_in = 16'h4000;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_mac_rst", 64'(mac_rst), 64'd0);
    check("midrst_ce_ab", 64'({ce, a_in, b_in}), 64'd0);
    check("midrst_y_out", 64'(y_out), 64'd0);
    check("midrst_flags", 64'({y_valid, busy, overrun}), 64'd0);
    saw_yv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (y_valid !== 1'b0) saw_yv = 1'b1;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (y_valid !== 1'b0) saw_yv = 1'b1;
    end
    check("midrst_no_y_valid", 64'(saw_yv), 64'd0);
    write_coef(4'd10, 16'h4000);
    write_coef(4'd13, 16'h2000);
    run_sample(16'h0000, 48'h0000_0000_0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/biquad_mac_sched.md
# biquad_mac_sched

Time-multiplexes the single MAC16_wrapper_accum multiply-accumulator across the three biquad bands of the real-time 3-band EQ. Each input sample runs 5 taps per band, 15 MACs in total. The block owns the coefficient store and the x/y history registers. It drives the MAC's clear, enable and operand ports, converts the Q4.28 accumulator result back to Q2.14 with saturation, and emits one output sample per band.

## Interface
- `NBANDS`, 3: number of biquad bands sharing the MAC.
- `MAC_LAT`, 3: cycles from the last `ce` until the MAC `result` includes that product.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe; `x_in` is a new sample.
- `x_in` in 16: input sample, signed Q2.14.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in 4: coefficient index = band*5 + tap. Taps: 0 b0, 1 b1, 2 b2, 3 −a1, 4 −a2. Indices 15 and above are ignored.
- `coef_wdata` in 16: coefficient, signed Q2.14. Feedback taps are stored pre-negated.
- `mac_rst` out 1: active-low accumulator clear to the MAC.
- `ce` out 1: MAC enable; one product is accepted per cycle `ce` is high.
- `a_in` out 16: MAC operand A (coefficient).
- `b_in` out 16: MAC operand B (history or sample).
- `result` in 32: MAC accumulator, signed Q4.28.
- `y_out` out NBANDS×16: per-band output, signed Q2.14, packed with band 0 in the LSBs.
- `y_valid` out 1: one-cycle strobe; all `y_out` lanes updated.
- `busy` out 1: high from acceptance of a sample until `y_valid`.
- `overrun` out 1: one-cycle pulse when a `sample_valid` is dropped.

## Operation
- **States:** IDLE, CLEAR, ISSUE, DRAIN, WRITEBACK, DONE.
- **IDLE:** `sample_valid` latches `x_in` into `x0`, sets band=0, and goes to CLEAR.
- **CLEAR:** `mac_rst`=0 for one cycle, then ISSUE with tap=0.
- **ISSUE:** five cycles with `ce`=1. `a_in` = coef[band*5+tap]. `b_in` per tap: 0 `x0`, 1 `x1`, 2 `x2`, 3 `y1[band]`, 4 `y2[band]`. Exits to DRAIN after tap 4.
- **DRAIN:** `ce`=0 for `MAC_LAT` cycles.
- **WRITEBACK:** saturates `result`, writes `y_out[band]`, sets `y2[band]←y1[band]` and `y1[band]←y`. If band<NBANDS−1: band+1 and back to CLEAR. Otherwise go to DONE.
- **DONE:** `y_valid`=1, `x2←x1`, `x1←x0`, return to IDLE.
- **x history:** shared by all bands, because every band filters the same input. y history is per band.
- **Saturation:** if `result[31:29]` are not all equal, y = 0x7FFF when `result[31]`=0, else 0x8000. Otherwise y = `result[29:14]` (truncate toward −∞).
- **Overrun:** a `sample_valid` arriving in any state other than IDLE is dropped and `overrun` pulses the same cycle. It is never queued.
- **Coefficient writes:** accepted in any state. The new value is seen by the first ISSUE read on the cycle after the write. A write to the entry being read in the same cycle returns the old value.
- **Idle outputs:** outside ISSUE, `a_in`=`b_in`=0 and `ce`=0. `mac_rst`=1 everywhere except CLEAR and reset.
- **Reset values:**
  - State IDLE; `mac_rst`=0, `ce`=0, `a_in`=`b_in`=0.
  - `y_out` all 0; `y_valid`, `busy`, `overrun` all 0.
  - All histories 0; all coefficients 0.
  - Reset mid-sequence abandons the sample and no `y_valid` is produced.

## Timing
- `sample_valid` is sampled at edge k.
- Band b CLEAR runs in cycle k+1+b·(7+MAC_LAT). ISSUE occupies the following 5 cycles.
- Per band: 7+MAC_LAT cycles.
- `y_valid` is asserted in cycle k+1+NBANDS·(7+MAC_LAT), i.e. k+31 with defaults.
- Next sample is accepted at edge k+32 or later.
- At 48 kHz the sample period is about 2083 cycles, so overrun indicates a system fault only.
- `busy` is high for cycles k+1 through k+31 inclusive.

## Structure
- **Package `eq_pkg`:**
  - state enum `sched_state_t`
  - tap index constants `TAP_B0`..`TAP_NA2`
  - `Q_FRAC`=14
  - `SAT_POS`=16'h7FFF, `SAT_NEG`=16'h8000
  - `NTAPS`=5
- **Sub-module `q28_to_q14_sat`:** combinational 32→16 saturating narrower, reused by other EQ blocks.
- The coefficient store is a 15×16 register array inside the scheduler. The MAC is instantiated outside, one level up.

## Test plan
- **Passthrough:** band 0 b0=0x4000, other coefficients 0; `x_in`=0x2000 → band 0 `y_out`=0x2000, bands 1–2 = 0, `y_valid` at k+31.
- **FIR impulse:** band 1 b0=0x0147, b1=0x028E, b2=0x0147; `x_in` sequence 0x4000, 0, 0, 0 → band 1 `y_out` 0x0147, 0x028E, 0x0147, 0x0000.
- **Feedback:** band 2 b0=0x4000, −a1=0x2000; impulse 0x4000 then zeros → 0x4000, 0x2000, 0x1000, 0x0800.
- **Saturation:** b0=0x7FFF with `x_in`=0x7FFF → 0x7FFF; with `x_in`=0x8000 → 0x8000.
- **Overrun:** second `sample_valid` at k+10 → `overrun` pulses at k+10; output still reflects only the first sample; `x1` unaffected.
- **Reset mid-operation:** assert `reset` at k+15 → all outputs go to reset values immediately, no `y_valid`. The next sample after release produces outputs computed with zero history.
